// File: rtl/rgb_fader.sv
// rgb_fader: 3-bit colour code to packed {R,G,B} word, with direct or
// stepped-fade transitions and busy/done status for the controller.
module rgb_fader #(
  parameter int unsigned CW   = 8,
  parameter int unsigned STEP = 1,
  parameter int unsigned DIV  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            mode,
  input  logic            load,
  input  logic [2:0]      colour,
  output logic [3*CW-1:0] rgb,
  output logic            busy,
  output logic            done
);

  localparam int unsigned RW = 3 * CW;
  localparam int unsigned DW = $clog2(DIV) + 1;
  localparam logic [CW:0]   STEP_X   = (CW+1)'(STEP);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [RW-1:0] target;
  logic [DW-1:0] div_cnt;
  logic [RW-1:0] rgb_n, tgt_n, lut_c, step_c;
  logic [DW-1:0] div_n;
  logic          done_n;

  // Each colour bit selects full intensity or zero for its channel.
  assign lut_c = {{CW{colour[2]}}, {CW{colour[1]}}, {CW{colour[0]}}};

  assign busy = (rgb != target);

  // One fade step per channel, clamped at the target so it never overshoots.
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [CW:0]   cur, tgt, up, dn, gap;
    logic [CW-1:0] nxt;

    assign cur = {1'b0, rgb[i*CW +: CW]};
    assign tgt = {1'b0, target[i*CW +: CW]};
    assign up  = cur + STEP_X;
    assign dn  = cur - STEP_X;
    assign gap = cur - tgt;

    // Up-ramp compares in CW+1 bits so a large step cannot wrap past full.
    always_comb begin
      nxt = cur[CW-1:0];
      if (cur < tgt) begin
        nxt = (up >= tgt) ? tgt[CW-1:0] : up[CW-1:0];
      end else if (cur > tgt) begin
        nxt = (gap <= STEP_X) ? tgt[CW-1:0] : dn[CW-1:0];
      end
    end

    assign step_c[i*CW +: CW] = nxt;
  end

  // Next-state selection; load outranks a coincident step, enable=0 freezes all.
  always_comb begin
    rgb_n  = rgb;
    tgt_n  = target;
    div_n  = div_cnt;
    done_n = done;
    if (enable) begin
      if (load) begin
        tgt_n = lut_c;
        div_n = '0;
        if (!mode) begin
          rgb_n  = lut_c;
          done_n = (lut_c != rgb);
        end else begin
          done_n = 1'b0;
        end
      end else if (busy) begin
        if (!mode) begin
          rgb_n  = target;
          div_n  = '0;
          done_n = 1'b1;
        end else if (div_cnt == DIV_LAST) begin
          rgb_n  = step_c;
          div_n  = '0;
          done_n = (step_c == target);
        end else begin
          div_n  = div_cnt + DW'(1);
          done_n = 1'b0;
        end
      end else begin
        div_n  = '0;
        done_n = 1'b0;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb     <= '0;
      target  <= '0;
      div_cnt <= '0;
      done    <= 1'b0;
    end else begin
      rgb     <= rgb_n;
      target  <= tgt_n;
      div_cnt <= div_n;
      done    <= done_n;
    end
  end

endmodule
